// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the alu_sequencer control unit.
// Opcodes, state encodings and instruction field positions.
package alu_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_JNZ  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS_MSB  = 3;
    localparam int RS_LSB  = 2;
    localparam int TGT_MSB = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_HALT
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// ROM and ALU bus between the sequencer (master) and
// the program ROM / adder ALU (slave).
interface alu_sequencer_if #(
    parameter int DW = alu_sequencer_pkg::DATA_W_DEF,
    parameter int AW = alu_sequencer_pkg::ADDR_W_DEF
);

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_y;

    modport master (
        output rom_addr,
        output alu_a,
        output alu_b,
        input  rom_data,
        input  alu_y
    );

    modport slave (
        input  rom_addr,
        input  alu_a,
        input  alu_b,
        output rom_data,
        output alu_y
    );

endinterface

// File: rtl/alu_regfile.sv
// 4-entry register file: two operand reads, one debug read,
// one synchronous write port, synchronous active-high reset.
module alu_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic [1:0]   wa_i,
    input  logic [W-1:0] wd_i,
    input  logic [1:0]   ra_a_i,
    input  logic [1:0]   ra_b_i,
    input  logic [1:0]   ra_dbg_i,
    output logic [W-1:0] rd_a_o,
    output logic [W-1:0] rd_b_o,
    output logic [W-1:0] rd_dbg_o
);

    logic [W-1:0] r_q [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
            end
        end else if (we_i) begin
            r_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o   = r_q[ra_a_i];
    assign rd_b_o   = r_q[ra_b_i];
    assign rd_dbg_o = r_q[ra_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle accumulator-style controller sequencing an
// external adder ALU from a combinational program ROM.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    alu_sequencer_if.master   bus,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              halted,
    output logic              zero
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              zero_q;
    logic              busy_q;
    logic              halted_q;

    logic [1:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [ADDR_W-1:0] tgt;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wd;

    assign op  = ir_q[OP_MSB:OP_LSB];
    assign rd  = ir_q[RD_MSB:RD_LSB];
    assign rs  = ir_q[RS_MSB:RS_LSB];
    assign tgt = ADDR_W'(ir_q[TGT_MSB:0]);

    // Writeback only from an ADD in DECODE or the LDI immediate.
    assign rf_we = (state_q == ST_IMM) ||
                   ((state_q == ST_DECODE) && (op == OP_ADD));
    assign rf_wd = (state_q == ST_IMM) ? bus.rom_data : bus.alu_y;

    alu_regfile #(.W(DATA_W)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (rf_we),
        .wa_i     (rd),
        .wd_i     (rf_wd),
        .ra_a_i   (rd),
        .ra_b_i   (rs),
        .ra_dbg_i (dbg_sel),
        .rd_a_o   (bus.alu_a),
        .rd_b_o   (bus.alu_b),
        .rd_dbg_o (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    ir_q    <= bus.rom_data;
                    pc_q    <= pc_q + ADDR_W'(1);
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    unique case (op)
                        OP_ADD: begin
                            zero_q  <= (bus.alu_y == '0);
                            state_q <= ST_FETCH;
                        end
                        OP_LDI: begin
                            state_q <= ST_IMM;
                        end
                        OP_JNZ: begin
                            if (!zero_q) begin
                                pc_q <= tgt;
                            end
                            state_q <= ST_FETCH;
                        end
                        OP_HALT: begin
                            state_q  <= ST_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    endcase
                end
                ST_IMM: begin
                    pc_q    <= pc_q + ADDR_W'(1);
                    state_q <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = pc_q;
    assign busy         = busy_q;
    assign halted       = halted_q;
    assign zero         = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with an
// array ROM and an adder ALU model on the slave side.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic       busy;
    logic       halted;
    logic       zero;

    logic [7:0] rom [64];
    int checks;
    int failures;

    alu_sequencer_if bus ();

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.alu_y    = bus.alu_a + bus.alu_b;

    alu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .busy     (busy),
        .halted   (halted),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic go;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 64; i++) rom[i] = 8'hC0;
    endtask

    task automatic rd_reg(input logic [1:0] s, output logic [7:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    task automatic load_basic;
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'h05;
        rom[2] = 8'h10; rom[3] = 8'h03;
        rom[4] = 8'h44; rom[5] = 8'hC0;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        clear_rom();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got b=%b h=%b z=%b exp 000",
                     busy, halted, zero);
        end
        checks++;
        if (bus.rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_pc: got %0d exp 0", bus.rom_addr);
        end
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            checks++;
            if (v !== 8'h00) begin
                failures++;
                $display("FAIL reset_r%0d: got %h exp 00", i, v);
            end
        end
        step(3);
        checks++;
        if (busy !== 1'b0 || bus.rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL idle_hold: got b=%b pc=%0d exp b=0 pc=0",
                     busy, bus.rom_addr);
        end
    endtask

    task automatic test_basic;
        logic [7:0] v;
        logic [7:0] exp [4];
        exp[0] = 8'h08; exp[1] = 8'h03;
        exp[2] = 8'h00; exp[3] = 8'h00;
        load_basic();
        do_reset();
        go();
        step(9);
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_early: got h=%b b=%b exp h=0 b=1",
                     halted, busy);
        end
        step(1);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_halt: got h=%b b=%b exp h=1 b=0",
                     halted, busy);
        end
        checks++;
        if (zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_zero: got %b exp 0", zero);
        end
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            checks++;
            if (v !== exp[i]) begin
                failures++;
                $display("FAIL basic_r%0d: got %h exp %h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] v;
        logic [7:0] exp [4];
        exp[0] = 8'h2C; exp[1] = 8'h64;
        exp[2] = 8'h00; exp[3] = 8'h80;
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'hC8;
        rom[2] = 8'h10; rom[3] = 8'h64;
        rom[4] = 8'h44;
        rom[5] = 8'h20; rom[6] = 8'h80;
        rom[7] = 8'h30; rom[8] = 8'h80;
        rom[9] = 8'h6C; rom[10] = 8'hC0;
        do_reset();
        go();
        step(8);
        rd_reg(2'd0, v);
        checks++;
        if (v !== 8'h2C || zero !== 1'b0) begin
            failures++;
            $display("FAIL wrap_add1: got r0=%h z=%b exp 2c z=0", v, zero);
        end
        step(10);
        checks++;
        if (halted !== 1'b1 || zero !== 1'b1) begin
            failures++;
            $display("FAIL wrap_add2: got h=%b z=%b exp h=1 z=1",
                     halted, zero);
        end
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            checks++;
            if (v !== exp[i]) begin
                failures++;
                $display("FAIL wrap_r%0d: got %h exp %h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_loop;
        logic [7:0] v;
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'h03;
        rom[2] = 8'h10; rom[3] = 8'hFF;
        rom[4] = 8'h44; rom[5] = 8'h84;
        rom[6] = 8'hC0;
        do_reset();
        go();
        step(19);
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL loop_early: got h=%b exp 0", halted);
        end
        step(1);
        checks++;
        if (halted !== 1'b1 || zero !== 1'b1 || bus.rom_addr !== 6'd7) begin
            failures++;
            $display("FAIL loop_end: got h=%b z=%b pc=%0d exp 1 1 7",
                     halted, zero, bus.rom_addr);
        end
        rd_reg(2'd0, v);
        checks++;
        if (v !== 8'h00) begin
            failures++;
            $display("FAIL loop_r0: got %h exp 00", v);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        load_basic();
        do_reset();
        go();
        step(5);
        rd_reg(2'd0, v);
        checks++;
        if (v !== 8'h05 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got r0=%h b=%b exp 05 1", v, busy);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_reg(2'(i), v);
            checks++;
            if (v !== 8'h00) begin
                failures++;
                $display("FAIL mid_r%0d: got %h exp 00", i, v);
            end
        end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || bus.rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL mid_state: got b=%b h=%b pc=%0d exp 0 0 0",
                     busy, halted, bus.rom_addr);
        end
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle: got b=%b exp 0", busy);
        end
        go();
        step(10);
        rd_reg(2'd0, v);
        checks++;
        if (v !== 8'h08 || halted !== 1'b1) begin
            failures++;
            $display("FAIL mid_rerun: got r0=%h h=%b exp 08 1", v, halted);
        end
    endtask

    task automatic test_start_ignored;
        logic [7:0] v;
        load_basic();
        do_reset();
        start = 1'b1;
        step(10);
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_busy: got h=%b b=%b exp 0 1", halted, busy);
        end
        step(1);
        rd_reg(2'd0, v);
        checks++;
        if (v !== 8'h08 || halted !== 1'b1 || bus.rom_addr !== 6'd6) begin
            failures++;
            $display("FAIL hold_run: got r0=%h h=%b pc=%0d exp 08 1 6",
                     v, halted, bus.rom_addr);
        end
        step(3);
        start = 1'b0;
        step(1);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus.rom_addr !== 6'd6) begin
            failures++;
            $display("FAIL hold_halt: got h=%b b=%b pc=%0d exp 1 0 6",
                     halted, busy, bus.rom_addr);
        end
    endtask

    task automatic test_pc_wrap;
        logic [7:0] v;
        clear_rom();
        rom[0]  = 8'h5A;
        rom[1]  = 8'h20; rom[2] = 8'h01;
        rom[3]  = 8'h78;
        rom[4]  = 8'hBF;
        rom[63] = 8'h00;
        do_reset();
        go();
        step(12);
        rd_reg(2'd0, v);
        checks++;
        if (v !== 8'h5A) begin
            failures++;
            $display("FAIL pcwrap_r0: got %h exp 5a", v);
        end
        checks++;
        if (bus.rom_addr !== 6'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pcwrap_pc: got pc=%0d b=%b exp 1 1",
                     bus.rom_addr, busy);
        end
        rd_reg(2'd3, v);
        checks++;
        if (v !== 8'h01 || zero !== 1'b0) begin
            failures++;
            $display("FAIL pcwrap_r3: got %h z=%b exp 01 0", v, zero);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dbg_sel  = 2'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_loop();
        test_reset_mid();
        test_start_ignored();
        test_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit that sequences the shared 8-bit adder ALU (Y = A + B) as a tiny accumulator-style processor.
- Fetches 8-bit instructions from an external combinational program ROM and holds a 4-entry register file.
- Drives the ALU operand buses, writes the ALU result back to the register file and keeps a zero flag.
- Sits between the program ROM and the ALU at the core of the MicroProcessor top level.

Parameters:
- DATA_W, 8, datapath/register/instruction width; must match ALU width.
- ADDR_W, 6, program counter / ROM address width (64-byte program space).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin execution from address 0; sampled only in IDLE.
- rom_addr  output  ADDR_W  program ROM address; equals pc.
- rom_data  input  DATA_W  ROM byte at rom_addr, combinational, same cycle.
- alu_a  output  DATA_W  ALU operand A = R[ir[5:4]].
- alu_b  output  DATA_W  ALU operand B = R[ir[3:2]].
- alu_y  input  DATA_W  ALU result.
- dbg_sel  input  2  register-file debug read select.
- dbg_data  output  DATA_W  R[dbg_sel], combinational.
- busy  output  1  high in FETCH, DECODE and IMM.
- halted  output  1  high in HALT.
- zero  output  1  zero flag.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On a clk edge with rst=1: state=IDLE, pc=0, ir=0, R0..R3=0, zero=0, busy=0, halted=0. Reset overrides any in-flight instruction, with no partial writeback.
- ISA (ir[7:6]):
  - 00 LDI rd: rd = ir[5:4]; the immediate is the next ROM byte.
  - 01 ADD rd,rs: rd = ir[5:4], rs = ir[3:2]; R[rd] <= alu_y.
  - 10 JNZ: target = ir[5:0], zero-extended or truncated to ADDR_W.
  - 11 HALT.
- FSM states: IDLE, FETCH, DECODE, IMM, HALT.
- IDLE:
  - start=1 -> FETCH with pc=0. Otherwise stay.
  - start is ignored in every other state.
- FETCH: ir <= rom_data; pc <= pc+1; -> DECODE.
- DECODE:
  - ADD: R[rd] <= alu_y; zero <= (alu_y==0); -> FETCH.
  - LDI: -> IMM.
  - JNZ: if zero==0 then pc <= target; -> FETCH.
  - HALT: -> HALT.
- IMM: R[rd] <= rom_data; pc <= pc+1; -> FETCH. LDI does not alter zero.
- HALT: hold all state until rst. start is ignored.
- Latency: ADD = 2 cycles, JNZ = 2, LDI = 3, HALT = 2 to reach the HALT state.
- Arithmetic:
  - Modulo 2^DATA_W; carry is discarded; the controller does not compute the sum itself.
  - ADD with rd==rs doubles the register.
- Wrap-around: pc increments modulo 2^ADDR_W (63 -> 0). An LDI at address 63 takes its immediate from address 0.
- alu_a and alu_b are driven from ir in every state. The register file is written only in DECODE (ADD) and IMM.
- dbg_data reflects register writes from the cycle after the write edge.

Decomposition:
- Shared package or header holds:
  - opcode constants OP_LDI=2'b00, OP_ADD=2'b01, OP_JNZ=2'b10, OP_HALT=2'b11;
  - state encodings ST_IDLE..ST_HALT;
  - instruction field slice positions.
- One natural sub-module: alu_regfile, a 4x DATA_W register file with two combinational read ports, one debug read port, one synchronous write port and synchronous reset.
- The ALU itself is instantiated at top level, not inside this block.

Test Plan:
- Reset then start; ROM = {LDI r0;05, LDI r1;03, ADD r0,r1, HALT} -> R0=8, R1=3, zero=0, halted=1 after 3+3+2+2 = 10 cycles from start, plus 1 cycle IDLE->FETCH.
- Wrap: LDI r0;C8, LDI r1;64, ADD r0,r1 -> R0=0x2C, zero=0. Then LDI r2;80, LDI r3;80, ADD r2,r3 -> R2=0x00, zero=1.
- Loop: LDI r0;03, LDI r1;FF, ADD r0,r1 at addr 4, JNZ 4, HALT -> ADD executes 3 times, R0=0, zero=1, halted=1, final pc=7.
- rst asserted during the IMM cycle of an LDI -> next cycle all registers 0, state IDLE, halted=0, busy=0. A later start re-runs from pc=0.
- start pulses while busy and while halted -> no effect on pc or state. dbg_sel sweep 0..3 returns R0..R3.
- PC wrap: JNZ 63 with zero=0, ROM[63]=LDI r0, ROM[0]=0x5A -> R0=0x5A, pc=1 afterwards.
